// File: rtl/collision_report_buffer_pkg.sv
// Shared constants and types for the collision report buffer.
package collision_pkg;

  localparam int ID_W_DEF  = 8;
  localparam int DEPTH_DEF = 16;
  localparam int CLR_W_DEF = 32;
  localparam int CNT_W_DEF = 16;

  // Bitmap words swept by CLEAR at default sizing (one word per cycle).
  localparam int NWORDS = (2 ** ID_W_DEF) / CLR_W_DEF;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/collision_report_buffer_if.sv
// Event input stream plus ready/valid drain port of the report buffer.
interface collision_report_buffer_if
  import collision_pkg::*;
#(
  parameter int ID_W = ID_W_DEF
) ();

  logic            in_val;
  logic [ID_W-1:0] lineID;
  logic            out_valid;
  logic [ID_W-1:0] out_id;
  logic            out_ready;

  // master: collision source + result consumer; slave: the buffer
  modport master (output in_val, lineID, out_ready, input out_valid, out_id);
  modport slave  (input in_val, lineID, out_ready, output out_valid, out_id);

endinterface

// File: rtl/collision_report_buffer_report_fifo.sv
// Synchronous FIFO with a registered head: the head register is loaded from
// the next-cycle state, so a push into an empty FIFO is visible after one edge.
module report_fifo #(
  parameter int ID_W  = 8,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [ID_W-1:0] push_data,
  input  logic            pop,
  input  logic            flush,
  output logic            full,
  output logic            empty,
  output logic [ID_W-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [ID_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d, remain;
  logic            head_vld_q, head_vld_d;
  logic [ID_W-1:0] head_q, head_d;
  logic            pop_eff, push_eff;

  // pointer/occupancy/head next-state; pointers wrap naturally (DEPTH is 2**AW)
  always_comb begin
    pop_eff    = pop && head_vld_q && !flush;
    push_eff   = push && !flush && (!full || pop_eff);
    rd_ptr_d   = rd_ptr_q + AW'(pop_eff);
    wr_ptr_d   = wr_ptr_q + AW'(push_eff);
    remain     = count_q - CW'(pop_eff);
    count_d    = remain + CW'(push_eff);
    head_vld_d = (count_d != '0);
    head_d     = head_q;
    if (remain == '0) begin
      // the slot being written now becomes the head
      if (push_eff) head_d = push_data;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      head_vld_d = 1'b0;
      head_d     = '0;
    end
  end

  // control and head registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      head_vld_q <= 1'b0;
      head_q     <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      head_vld_q <= head_vld_d;
      head_q     <= head_d;
    end
  end

  // storage array, no reset needed (guarded by count)
  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= push_data;
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = !head_vld_q;
  assign head  = head_q;

endmodule

// File: rtl/collision_report_buffer.sv
// Dedups CollisionDetect line IDs with a seen-bitmap, queues unique IDs and
// drains them over ready/valid; keeps hit/unique counters and an overflow flag.
module collision_report_buffer
  import collision_pkg::*;
#(
  parameter int ID_W  = ID_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CLR_W = CLR_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  collision_report_buffer_if.slave   bus,
  output logic                       busy,
  output logic                       overflow,
  output logic [CNT_W-1:0]           hit_count,
  output logic [CNT_W-1:0]           uniq_count
);

  localparam int NBITS   = 2 ** ID_W;
  localparam int N_WORDS = NBITS / CLR_W;
  localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WORDS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NBITS-1:0] bitmap_q, bitmap_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] hit_q, hit_d, uniq_q, uniq_d;
  logic             in_run, take, seen, can_accept;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ID_W-1:0]  fifo_head;

  // state, sweep index and report registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      hit_q      <= '0;
      uniq_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      hit_q      <= hit_d;
      uniq_q     <= uniq_d;
    end
  end

  // bitmap contents are defined by the CLEAR sweep, not by reset
  always_ff @(posedge clk) begin
    bitmap_q <= bitmap_d;
  end

  // next state: sweep one word per cycle, clear restarts the sweep
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      CLEAR: begin
        if (clear) begin
          idx_d = '0;
        end else if (idx_q == IDX_LAST) begin
          state_d = RUN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      RUN: begin
        if (clear) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  // FSM-decoded outputs
  always_comb begin
    busy   = (state_q == CLEAR);
    in_run = (state_q == RUN);
  end

  // dedup, bitmap update, counters and overflow
  always_comb begin
    fifo_pop   = !fifo_empty && bus.out_ready;
    can_accept = !fifo_full || fifo_pop;
    seen       = bitmap_q[bus.lineID];
    take       = in_run && !clear && bus.in_val;
    fifo_push  = take && !seen && can_accept;
    bitmap_d   = bitmap_q;
    overflow_d = overflow_q;
    hit_d      = hit_q;
    uniq_d     = uniq_q;
    if (!in_run) begin
      for (int w = 0; w < N_WORDS; w++) begin
        if (idx_q == IDX_W'(w)) bitmap_d[w*CLR_W +: CLR_W] = '0;
      end
    end
    if (clear) begin
      overflow_d = 1'b0;
      hit_d      = '0;
      uniq_d     = '0;
    end else if (take) begin
      hit_d = (hit_q == '1) ? hit_q : hit_q + CNT_W'(1);
      if (!seen) begin
        if (can_accept) begin
          bitmap_d[bus.lineID] = 1'b1;
          uniq_d = (uniq_q == '1) ? uniq_q : uniq_q + CNT_W'(1);
        end else begin
          // bit stays clear so a later repeat can retry
          overflow_d = 1'b1;
        end
      end
    end
  end

  report_fifo #(.ID_W(ID_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (bus.lineID),
    .pop       (fifo_pop),
    .flush     (clear),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_id    = fifo_head;
  assign overflow      = overflow_q;
  assign hit_count     = hit_q;
  assign uniq_count    = uniq_q;

endmodule

// File: tb/tb_collision_report_buffer.sv
// Bench for collision_report_buffer: directed scenarios plus random traffic,
// all checked against a queue/set reference model after every clock edge.
module tb_collision_report_buffer;
  import collision_pkg::*;

  localparam int ID_W  = 8;
  localparam int DEPTH = DEPTH_DEF;
  localparam int CNT_W = 16;
  localparam int CMAX  = (2 ** CNT_W) - 1;

  logic             clk, reset, clear;
  logic             busy, overflow;
  logic [CNT_W-1:0] hit_count, uniq_count;

  collision_report_buffer_if #(.ID_W(ID_W)) bus ();

  collision_report_buffer #(
    .ID_W(ID_W), .DEPTH(DEPTH), .CLR_W(CLR_W_DEF), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .bus        (bus),
    .busy       (busy),
    .overflow   (overflow),
    .hit_count  (hit_count),
    .uniq_count (uniq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // reference model: ordered list of pending IDs, set of IDs seen this frame
  logic [ID_W-1:0] m_q[$];
  bit              m_seen[2**ID_W];
  bit              m_ovf;
  int              m_hit, m_uniq, m_sweep;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 2**ID_W; i++) m_seen[i] = 1'b0;
    m_ovf   = 1'b0;
    m_hit   = 0;
    m_uniq  = 0;
    m_sweep = NWORDS;
  endtask

  task automatic model_edge(input bit c, input bit iv, input logic [ID_W-1:0] id, input bit rdy);
    bit pop;
    pop = (m_q.size() > 0) && rdy;
    if (c) begin
      model_reset();
    end else if (m_sweep > 0) begin
      m_sweep--;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (iv) begin
        if (m_hit < CMAX) m_hit++;
        if (!m_seen[id]) begin
          if (m_q.size() < DEPTH) begin
            m_seen[id] = 1'b1;
            m_q.push_back(id);
            if (m_uniq < CMAX) m_uniq++;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".busy"},  32'(busy),           32'(m_sweep > 0));
    chk({tag, ".valid"}, 32'(bus.out_valid),  32'(m_q.size() > 0));
    if (m_q.size() > 0) chk({tag, ".id"}, 32'(bus.out_id), 32'(m_q[0]));
    chk({tag, ".ovf"},   32'(overflow),       32'(m_ovf));
    chk({tag, ".hit"},   32'(hit_count),      32'(m_hit));
    chk({tag, ".uniq"},  32'(uniq_count),     32'(m_uniq));
  endtask

  task automatic step(input bit c, input bit iv, input logic [ID_W-1:0] id, input bit rdy,
                      input string tag);
    clear         = c;
    bus.in_val    = iv;
    bus.lineID    = id;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
    model_edge(c, iv, id, rdy);
    check_all(tag);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".busy"},  32'(busy),          32'h1);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'h0);
    chk({tag, ".id"},    32'(bus.out_id),    32'h0);
    chk({tag, ".ovf"},   32'(overflow),      32'h0);
    chk({tag, ".hit"},   32'(hit_count),     32'h0);
    chk({tag, ".uniq"},  32'(uniq_count),    32'h0);
  endtask

  initial begin
    int          pct;
    bit          rc, riv, rrdy;
    logic [7:0]  rid;

    reset = 1'b1; clear = 1'b0;
    bus.in_val = 1'b0; bus.lineID = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("rst");
    reset = 1'b0;
    model_reset();

    // 1: busy for exactly NWORDS cycles after release
    for (int i = 0; i < NWORDS - 1; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, "t1");
      chk("t1.busy_hi", 32'(busy), 32'h1);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, "t1");
    chk("t1.busy_lo", 32'(busy), 32'h0);

    // 2: duplicate removal with a free-running consumer
    step(1'b0, 1'b1, 8'h05, 1'b1, "t2");
    chk("t2.first", 32'(bus.out_id), 32'h05);
    step(1'b0, 1'b1, 8'h05, 1'b1, "t2");
    step(1'b0, 1'b1, 8'h07, 1'b1, "t2");
    chk("t2.second", 32'(bus.out_id), 32'h07);
    step(1'b0, 1'b1, 8'h05, 1'b1, "t2");
    chk("t2.hits", 32'(hit_count), 32'd4);
    chk("t2.uniq", 32'(uniq_count), 32'd2);
    step(1'b0, 1'b0, 8'h00, 1'b1, "t2");

    // 3: overfill with a stalled consumer, drain in order, retry the dropped ID
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, "t3.fill");
    chk("t3.ovf", 32'(overflow), 32'h1);
    for (int i = 0; i < 16; i++) begin
      chk("t3.order", 32'(bus.out_id), 32'(8'h10 + i));
      step(1'b0, 1'b0, 8'h00, 1'b1, "t3.drain");
    end
    chk("t3.empty", 32'(bus.out_valid), 32'h0);
    step(1'b0, 1'b1, 8'h20, 1'b1, "t3.retry");
    chk("t3.retry_id", 32'(bus.out_id), 32'h20);
    step(1'b0, 1'b0, 8'h00, 1'b1, "t3");

    // new frame, then 4: push into a full FIFO while it pops
    step(1'b1, 1'b0, 8'h00, 1'b1, "clr");
    for (int i = 0; i < NWORDS; i++) step(1'b0, 1'b0, 8'h00, 1'b1, "clr.sweep");
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(8'h30 + i), 1'b0, "t4.fill");
    step(1'b0, 1'b1, 8'h40, 1'b1, "t4.pushpop");
    chk("t4.no_ovf", 32'(overflow), 32'h0);
    chk("t4.head", 32'(bus.out_id), 32'h31);
    step(1'b0, 1'b1, 8'h41, 1'b0, "t4.still_full");
    chk("t4.full_ovf", 32'(overflow), 32'h1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00, 1'b1, "t4.drain");

    // 5: clear mid-frame with entries queued; events during the sweep are ignored
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'h50 + i), 1'b0, "t5.q");
    step(1'b1, 1'b0, 8'h00, 1'b0, "t5.clr");
    chk("t5.valid", 32'(bus.out_valid), 32'h0);
    chk("t5.hits", 32'(hit_count), 32'h0);
    for (int i = 0; i < NWORDS - 1; i++) begin
      step(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1, "t5.sweep");
      chk("t5.busy", 32'(busy), 32'h1);
    end
    step(1'b0, 1'b1, 8'h06, 1'b1, "t5.sweep");
    chk("t5.done", 32'(busy), 32'h0);
    step(1'b0, 1'b1, 8'h05, 1'b1, "t5.reaccept");
    chk("t5.id", 32'(bus.out_id), 32'h05);
    chk("t5.uniq", 32'(uniq_count), 32'h1);

    // random traffic with varying consumer throughput and occasional clears
    for (int i = 0; i < 600; i++) begin
      case ((i / 100) % 4)
        0: pct = 90;
        1: pct = 20;
        2: pct = 60;
        default: pct = 5;
      endcase
      rc   = ($urandom_range(0, 99) == 0);
      riv  = ($urandom_range(0, 3) != 0);
      rid  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 47));
      rrdy = ($urandom_range(0, 99) < pct);
      step(rc, riv, rid, rrdy, "rnd");
    end

    // 6: asynchronous reset between edges
    step(1'b0, 1'b0, 8'h00, 1'b1, "t6.pre");
    while (busy) step(1'b0, 1'b0, 8'h00, 1'b1, "t6.wait");
    step(1'b0, 1'b1, 8'h60, 1'b0, "t6.q");
    step(1'b0, 1'b1, 8'h61, 1'b0, "t6.q");
    #3;
    reset = 1'b1;
    #1;
    chk_reset_values("t6.async");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < NWORDS; i++) step(1'b0, 1'b0, 8'h00, 1'b1, "t6.sweep");
    step(1'b0, 1'b1, 8'h60, 1'b1, "t6.accept");
    chk("t6.id", 32'(bus.out_id), 32'h60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
